// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive halves of the link.
// Holds the frame state encoding, the default line settings and the baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int DEFAULT_CLK_FREQ  = 100_000_000;
  localparam int DEFAULT_BAUD_RATE = 9600;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: emits a one-clock tick every DIVISOR clocks while not cleared.
// The count restarts from 0 after each tick and is held at 0 while i_clr is high.
module uart_baud_tick #(
  parameter int DIVISOR = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign o_tick = !i_clr && w_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// A one-byte holding register lets back-to-back bytes leave with no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE = DEFAULT_BAUD_RATE,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CLKS_PER_BIT = baud_div(CLK_FREQ, BAUD_RATE);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_state_t r_state, w_state_next;
  logic [7:0]  r_shift, r_hold;
  logic        r_hold_full, r_parity;
  logic [2:0]  r_bit_idx;
  logic        r_stop_idx;
  logic        r_tx, r_busy, r_done_evt, r_done;
  logic        w_tick, w_accept, w_frame_end, w_load;

  uart_baud_tick #(.DIVISOR(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .i_clr (r_state == IDLE),
    .o_tick(w_tick)
  );

  assign w_accept    = tx_valid && !r_hold_full;
  assign w_frame_end = (r_state == STOP) && w_tick && (r_stop_idx == 1'(STOP_BITS - 1));
  assign w_load      = r_hold_full && ((r_state == IDLE) || w_frame_end);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (r_hold_full) w_state_next = START;
      START:   if (w_tick) w_state_next = DATA;
      DATA:    if (w_tick && r_bit_idx == 3'd7) w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (w_tick) w_state_next = STOP;
      STOP:    if (w_frame_end) w_state_next = r_hold_full ? START : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_parity    <= 1'b0;
      r_bit_idx   <= '0;
      r_stop_idx  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // A load takes the old holding byte while an accept may refill the holding reg.
      if (w_load) begin
        r_shift  <= r_hold;
        r_parity <= ^r_hold;
      end else if (r_state == DATA && w_tick) begin
        r_shift <= {1'b0, r_shift[7:1]};
      end
      if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
      if (w_load) begin
        r_bit_idx <= '0;
      end else if (r_state == DATA && w_tick) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end
      if (w_load || w_frame_end) begin
        r_stop_idx <= 1'b0;
      end else if (r_state == STOP && w_tick) begin
        r_stop_idx <= 1'b1;
      end
    end
  end

  // Line-side outputs trail the state by one clock so tx, tx_busy and tx_done stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done_evt <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_busy     <= (r_state != IDLE);
      r_done_evt <= w_frame_end;
      r_done     <= r_done_evt;
      unique case (r_state)
        START:   r_tx <= 1'b0;
        DATA:    r_tx <= r_shift[0];
        PARITY:  r_tx <= r_parity;
        default: r_tx <= 1'b1;
      endcase
    end
  end

  assign tx       = r_tx;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;
  assign tx_ready = !r_hold_full;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table of directed frames, hand sequences for the corner cases,
// and a randomized scoreboard run that decodes the serial line of two configurations.
module tb_uart_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 125_000;
  localparam int C        = CLK_FREQ / BAUD;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0][7:0] tx_data;
  logic [1:0]      tx_valid, tx_ready, tx_line, tx_busy, tx_done;

  int vectors     = 0;
  int miscompares = 0;

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx(tx_line[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0])
  );

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx(tx_line[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1])
  );

  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    logic [7:0]  data;
    logic [11:0] frame;   // line bits in time order, bit 0 first
    int          nbits;
  } vec_t;

  vec_t vtab[8];

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic wait_ready(input int d);
    int n = 0;
    while (!tx_ready[d] && n < 40 * C) begin
      tick();
      n++;
    end
    if (!tx_ready[d]) check("ready_timeout", 0, 1);
  endtask

  task automatic send(input int d, input logic [7:0] b);
    tx_valid[d] = 1'b1;
    tx_data[d]  = b;
    wait_ready(d);
    tick();
    tx_valid[d] = 1'b0;
  endtask

  // Exact cycle-by-cycle check of one isolated frame from an idle transmitter.
  task automatic run_vector(input int d, input logic [7:0] b, input logic [11:0] frame,
                            input int nbits);
    int bad = 0;
    tx_valid[d] = 1'b1;
    tx_data[d]  = b;
    wait_ready(d);
    tick();
    tx_valid[d] = 1'b0;
    check($sformatf("v%0h_ready_low", b), int'(tx_ready[d]), 0);
    tick();
    check($sformatf("v%0h_ready_back", b), int'(tx_ready[d]), 1);
    check($sformatf("v%0h_pre_start", b), int'({tx_line[d], tx_busy[d]}), 2);
    for (int j = 0; j < nbits * C; j++) begin
      tick();
      if (tx_line[d] !== frame[j / C] || tx_busy[d] !== 1'b1 || tx_done[d] !== 1'b0) bad++;
    end
    check($sformatf("v%0h_frame_errs", b), bad, 0);
    tick();
    check($sformatf("v%0h_done", b), int'({tx_done[d], tx_busy[d], tx_line[d]}), 5);
    tick();
    check($sformatf("v%0h_done_clear", b), int'(tx_done[d]), 0);
  endtask

  // Samples each bit at its centre; stop/parity/start errors clear ok.
  task automatic decode(input int d, output logic [7:0] b, output logic ok);
    int n = 0;
    b  = '0;
    ok = 1'b1;
    while (tx_line[d] && n < 60 * C) begin
      tick();
      n++;
    end
    if (tx_line[d]) begin
      ok = 1'b0;
      return;
    end
    repeat (C / 2) tick();
    if (tx_line[d] !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (C) tick();
      b[i] = tx_line[d];
    end
    if (d == 1) begin
      repeat (C) tick();
      if (tx_line[d] !== (^b)) ok = 1'b0;
    end
    for (int s = 0; s < d + 1; s++) begin
      repeat (C) tick();
      if (tx_line[d] !== 1'b1) ok = 1'b0;
    end
  endtask

  initial begin
    logic [7:0]  got;
    logic        ok;
    int          bad, dones, lows;
    logic [11:0] fa, fb;

    vtab[0] = '{0, 8'h55, 12'h2AA, 10};
    vtab[1] = '{0, 8'hA3, 12'h346, 10};
    vtab[2] = '{0, 8'h00, 12'h200, 10};
    vtab[3] = '{0, 8'hFF, 12'h3FE, 10};
    vtab[4] = '{1, 8'h07, 12'hE0E, 12};
    vtab[5] = '{1, 8'hFF, 12'hDFE, 12};
    vtab[6] = '{1, 8'h00, 12'hC00, 12};
    vtab[7] = '{1, 8'h81, 12'hD02, 12};

    reset    = 1'b1;
    tx_valid = '0;
    tx_data  = '0;
    #22;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_tx%0d", d), int'(tx_line[d]), 1);
      check($sformatf("rst_ready%0d", d), int'(tx_ready[d]), 1);
      check($sformatf("rst_busy%0d", d), int'(tx_busy[d]), 0);
      check($sformatf("rst_done%0d", d), int'(tx_done[d]), 0);
    end
    tick();
    reset = 1'b0;
    repeat (3) tick();

    for (int v = 0; v < 8; v++) run_vector(vtab[v].dut, vtab[v].data, vtab[v].frame, vtab[v].nbits);

    // Back-to-back: valid held across two bytes, frames must abut with no idle clock.
    fa = 12'h346;
    fb = 12'h21E;
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'hA3;
    wait_ready(0);
    tick();
    check("b2b_ready_low1", int'(tx_ready[0]), 0);
    tx_data[0] = 8'h0F;
    tick();
    check("b2b_ready_high", int'(tx_ready[0]), 1);
    tick();
    tx_valid[0] = 1'b0;
    check("b2b_ready_low2", int'(tx_ready[0]), 0);
    bad   = 0;
    dones = 0;
    for (int j = 0; j <= 20 * C; j++) begin
      if (j > 0) tick();
      if (j < 10 * C) begin
        if (tx_line[0] !== fa[j / C]) bad++;
      end else if (j < 20 * C) begin
        if (tx_line[0] !== fb[j / C - 10]) bad++;
      end
      if (j < 20 * C && tx_busy[0] !== 1'b1) bad++;
      if (tx_done[0]) dones++;
      if (j == 10 * C) check("b2b_done_first", int'(tx_done[0]), 1);
      if (j == 20 * C) check("b2b_done_second", int'({tx_done[0], tx_busy[0]}), 2);
      if (j == C) check("b2b_hold_full", int'(tx_ready[0]), 0);
    end
    check("b2b_line_errs", bad, 0);
    check("b2b_done_count", dones, 2);
    repeat (3) tick();

    // A valid pulse while the holding register is full must be dropped.
    fork
      begin
        send(0, 8'h3C);
        send(0, 8'h5A);
        check("ign_ready_low", int'(tx_ready[0]), 0);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'hFF;
        tick();
        tx_valid[0] = 1'b0;
      end
      begin
        decode(0, got, ok);
        check("ign_frame1", int'({ok, got}), 'h13C);
        decode(0, got, ok);
        check("ign_frame2", int'({ok, got}), 'h15A);
      end
    join
    lows = 0;
    for (int j = 0; j < 15 * C; j++) begin
      tick();
      if (!tx_line[0]) lows++;
    end
    check("ign_no_third_frame", lows, 0);

    // Reset in the middle of data bit 3 of 0xC3.
    send(0, 8'hC3);
    repeat (1 + 4 * C + C / 2) tick();
    check("c3_bit3_on_line", int'({tx_line[0], tx_busy[0]}), 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_line", int'({tx_line[0], tx_ready[0], tx_busy[0], tx_done[0]}), 'b1100);
    tick();
    tick();
    reset = 1'b0;
    dones = 0;
    lows  = 0;
    for (int j = 0; j < 12 * C; j++) begin
      tick();
      if (tx_done[0]) dones++;
      if (!tx_line[0]) lows++;
    end
    check("mid_rst_no_done", dones, 0);
    check("mid_rst_line_idle", lows, 0);
    run_vector(0, 8'h81, 12'h302, 10);

    // Random traffic on both configurations against a queue scoreboard.
    fork
      begin
        for (int k = 0; k < 256; k++) begin
          logic [7:0] r;
          r = 8'($urandom);
          repeat ($urandom_range(0, 2 * C)) tick();
          send(0, r);
          q_a.push_back(r);
        end
      end
      begin
        for (int k = 0; k < 256; k++) begin
          logic [7:0] rb;
          logic       rok;
          decode(0, rb, rok);
          if (q_a.size() == 0) check("rand_a_unexpected", 1, 0);
          else check($sformatf("rand_a_%0d", k), int'({rok, rb}), int'({1'b1, q_a.pop_front()}));
        end
      end
      begin
        for (int k = 0; k < 64; k++) begin
          logic [7:0] r;
          r = 8'($urandom);
          repeat ($urandom_range(0, 3 * C)) tick();
          send(1, r);
          q_b.push_back(r);
        end
      end
      begin
        for (int k = 0; k < 64; k++) begin
          logic [7:0] rb;
          logic       rok;
          decode(1, rb, rok);
          if (q_b.size() == 0) check("rand_b_unexpected", 1, 0);
          else check($sformatf("rand_b_%0d", k), int'({rok, rb}), int'({1'b1, q_b.pop_front()}));
        end
      end
    join
    repeat (2 * C) tick();
    check("rand_end_idle", int'({tx_line, tx_busy}), 'b1100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
